jtag_master: RTL

Host-side JTAG initiator that drives a TAP (TCK/TMS/TDI/TRST) and samples TDO on behalf of on-chip logic or a debug bridge. It accepts one scan command at a time (IR or DR, 1..DR_WIDTH bits), walks the target TAP from Run-Test/Idle through Capture/Shift/Exit1/Update back to Run-Test/Idle, and returns the captured TDO bits. It is the counterpart to the TAP-side instruction and data registers (`dr_reg`) and sits between the system clock domain and the JTAG pins.

---
 rtl/jtag_master.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/jtag_master.sv
// jtag_master: host-side JTAG initiator. Accepts one IR or DR scan command at a
// time, walks the target TAP Run-Test/Idle -> Capture -> Shift -> Exit1 ->
// Update -> Run-Test/Idle, and returns the TDO bits sampled during Shift.
// Optional feature macro: JTAG_MASTER_RESET_SEQ_EN adds a TMS-based TAP reset
// walk (5x TMS=1, 1x TMS=0) after TRST deasserts.
module jtag_master #(
  parameter int DR_WIDTH = 8,
  parameter int CLK_DIV  = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic                             cmd_ir_i,
  input  logic [$clog2(DR_WIDTH+1)-1:0]    cmd_len_i,
  input  logic [DR_WIDTH-1:0]              cmd_data_i,
  output logic                             rsp_valid_o,
  output logic [DR_WIDTH-1:0]              rsp_data_o,
  output logic                             tck_o,
  output logic                             tms_o,
  output logic                             tdi_o,
  input  logic                             tdo_i,
  output logic                             trst_o
);

  localparam int LEN_W = $clog2(DR_WIDTH + 1);
  localparam int DIV_W = $clog2(2 * CLK_DIV);
  // TCK rises at the end of the first half-period and falls at the end of the second.
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);

  // Each scan state names the TCK cycle being driven; CAPTURE spans two cycles
  // (into Capture, then Capture -> Shift).
  typedef enum logic [3:0] {
    RESET_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, DONE
  } state_t;

  state_t               state;
  logic [DIV_W-1:0]     div_cnt;
  logic [2:0]           cyc_cnt;
  logic [LEN_W-1:0]     bit_cnt;
  logic [LEN_W-1:0]     len_reg;
  logic [LEN_W-1:0]     len_eff;
  logic                 ir_reg;
  logic [DR_WIDTH-1:0]  tx_reg;
  logic [DR_WIDTH-1:0]  cap_reg;

  // Clamp the requested scan length into 1..DR_WIDTH.
  always_comb begin
    len_eff = cmd_len_i;
    if (cmd_len_i == '0)
      len_eff = LEN_W'(1);
    else if (cmd_len_i > LEN_W'(DR_WIDTH))
      len_eff = LEN_W'(DR_WIDTH);
  end

  // Control FSM with TCK divider; all pin and handshake outputs are registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= RESET_SEQ;
      div_cnt     <= '0;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      len_reg     <= '0;
      ir_reg      <= 1'b0;
      tx_reg      <= '0;
      cap_reg     <= '0;
      tck_o       <= 1'b0;
      tms_o       <= 1'b1;
      tdi_o       <= 1'b0;
      trst_o      <= 1'b1;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
    end else begin
      case (state)
        RESET_SEQ: begin
          if (trst_o) begin
            // Hold TRST for two TCK periods with TCK parked low.
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              if (cyc_cnt == 3'd1) begin
                trst_o  <= 1'b0;
                cyc_cnt <= '0;
              end else begin
                cyc_cnt <= cyc_cnt + 3'd1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end else begin
`ifdef JTAG_MASTER_RESET_SEQ_EN
            // Five TMS=1 cycles reach Test-Logic-Reset, one TMS=0 reaches Run-Test/Idle.
            if (div_cnt == DIV_HALF) begin
              tck_o   <= 1'b1;
              div_cnt <= div_cnt + 1'b1;
            end else if (div_cnt == DIV_LAST) begin
              tck_o   <= 1'b0;
              div_cnt <= '0;
              if (cyc_cnt == 3'd5) begin
                state       <= IDLE;
                cmd_ready_o <= 1'b1;
                tms_o       <= 1'b0;
              end else begin
                cyc_cnt <= cyc_cnt + 3'd1;
                tms_o   <= (cyc_cnt != 3'd4);
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
`else
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            tms_o       <= 1'b0;
`endif
          end
        end
        IDLE: begin
          rsp_valid_o <= 1'b0;
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            ir_reg      <= cmd_ir_i;
            len_reg     <= len_eff;
            tx_reg      <= cmd_data_i;
            cap_reg     <= '0;
            div_cnt     <= '0;
            tms_o       <= 1'b1;
            state       <= SEL_DR;
          end else begin
            cmd_ready_o <= 1'b1;
          end
        end
        DONE: begin
          // Captured bits entered from the top; align bit 0 to the first sample.
          rsp_valid_o <= 1'b1;
          rsp_data_o  <= cap_reg >> (DR_WIDTH - int'(len_reg));
          state       <= IDLE;
        end
        default: begin
          if (div_cnt == DIV_HALF) begin
            tck_o   <= 1'b1;
            div_cnt <= div_cnt + 1'b1;
            if (state == SHIFT)
              cap_reg <= {tdo_i, cap_reg[DR_WIDTH-1:1]};
          end else if (div_cnt == DIV_LAST) begin
            // Falling edge: move to the next TCK cycle and present its TMS/TDI.
            tck_o   <= 1'b0;
            div_cnt <= '0;
            case (state)
              SEL_DR: begin
                if (ir_reg) begin
                  state <= SEL_IR;
                  tms_o <= 1'b1;
                end else begin
                  state   <= CAPTURE;
                  cyc_cnt <= '0;
                  tms_o   <= 1'b0;
                end
              end
              SEL_IR: begin
                state   <= CAPTURE;
                cyc_cnt <= '0;
                tms_o   <= 1'b0;
              end
              CAPTURE: begin
                if (cyc_cnt == 3'd0) begin
                  cyc_cnt <= 3'd1;
                  tms_o   <= 1'b0;
                end else begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
                  tms_o   <= (len_reg == LEN_W'(1));
                  tdi_o   <= tx_reg[0];
                  tx_reg  <= tx_reg >> 1;
                end
              end
              SHIFT: begin
                if (bit_cnt == len_reg - 1'b1) begin
                  state <= EXIT1;
                  tms_o <= 1'b1;
                  tdi_o <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  tms_o   <= ((bit_cnt + 1'b1) == (len_reg - 1'b1));
                  tdi_o   <= tx_reg[0];
                  tx_reg  <= tx_reg >> 1;
                end
              end
              EXIT1: begin
                state <= UPDATE;
                tms_o <= 1'b0;
              end
              UPDATE: begin
                state <= DONE;
                tms_o <= 1'b0;
              end
              default: state <= IDLE;
            endcase
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
